// File: rtl/io_input_unit_pkg.sv
// rtl/io_input_unit_pkg.sv - shared types and helpers for the input front-end
package io_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    DONE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(value)) w = w + 1;
    end
    return w;
  endfunction

  // A one-cycle debounce still needs a 1-bit counter register.
  function automatic int cnt_width(input int cycles);
    return (clog2(cycles) < 1) ? 1 : clog2(cycles);
  endfunction

endpackage

// File: rtl/io_input_unit_if.sv
// rtl/io_input_unit_if.sv - CPU input-instruction handshake bundle
interface io_input_unit_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic              req;
  logic              sign_ext;
  logic [DATA_W-1:0] switches;
  logic              stall;
  logic              valid;
  logic [OUT_W-1:0]  data_out;

  modport master (output req, sign_ext, switches, input stall, valid, data_out);
  modport slave  (input req, sign_ext, switches, output stall, valid, data_out);
endinterface

// File: rtl/io_input_unit_debounce_channel.sv
// rtl/io_input_unit_debounce_channel.sv - one button: synchroniser, debounce counter, press pulse
module debounce_channel
  import io_input_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic clock,
  input  logic n_reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CNT_W = cnt_width(DB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= ~raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/io_input_unit.sv
// rtl/io_input_unit.sv - debounced buttons plus the input-instruction stall/capture handshake
module io_input_unit
  import io_input_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 32,
  parameter int N_BTN     = 2,
  parameter int DB_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  io_input_unit_if.slave   bus
);
  state_t           state;
  logic             valid_q;
  logic [OUT_W-1:0] data_q;
  logic [OUT_W-1:0] ext;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_chan (
      .clock   (clock),
      .n_reset (n_reset),
      .raw     (btn_raw[i]),
      .level   (btn_level[i]),
      .press   (btn_press[i])
    );
  end

  // Upper-bit mask is empty when OUT_W == DATA_W, so no special case is needed.
  always_comb begin
    ext = OUT_W'(bus.switches);
    if (bus.sign_ext && bus.switches[DATA_W-1]) ext = ext | ~OUT_W'({DATA_W{1'b1}});
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.req) state <= WAIT_PRESS;
        WAIT_PRESS: begin
          if (!bus.req) begin
            state <= IDLE;
          end else if (btn_press[0]) begin
            data_q  <= ext;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: state <= btn_level[0] ? WAIT_RELEASE : IDLE;
        // A held enter button must be released before it can serve another request.
        WAIT_RELEASE: if (!btn_level[0]) state <= bus.req ? WAIT_PRESS : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall    = bus.req & (state != DONE);
  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_io_input_unit.sv
// tb/tb_io_input_unit.sv - randomized and directed bench for io_input_unit against a history-based model
module tb_io_input_unit;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 32;
  localparam int N_BTN  = 2;
  localparam int DB     = 4;

  logic             clock = 1'b0;
  logic             n_reset;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;

  io_input_unit_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  io_input_unit #(.DATA_W(DATA_W), .OUT_W(OUT_W), .N_BTN(N_BTN), .DB_CYCLES(DB)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int press1_cnt = 0;

  // Reference state: raw press history and a sliding window of synchronised samples per button.
  bit               pq[N_BTN][$];
  bit               wq[N_BTN][$];
  logic [N_BTN-1:0] m_level = '0, m_press = '0, m_rose = '0;
  bit               m_armed = 0, m_done = 0, m_hold = 0, m_valid = 0;
  logic [OUT_W-1:0] m_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [OUT_W-1:0] extend(input logic [DATA_W-1:0] sw, input logic sx);
    logic [OUT_W-1:0] e;
    e = {16'h0000, sw};
    if (sx && sw[DATA_W-1]) e = e | 32'hFFFF_0000;
    return e;
  endfunction

  task automatic model_edge();
    bit lv0, pr0, sv, all_diff;
    if (!n_reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        pq[i].delete();
        wq[i].delete();
      end
      m_level = '0; m_press = '0; m_rose = '0;
      m_armed = 0; m_done = 0; m_hold = 0; m_valid = 0; m_data = '0;
    end else begin
      lv0 = m_level[0];
      pr0 = m_press[0];
      m_valid = 0;
      if (m_done) begin
        m_done = 0;
        m_hold = lv0;
      end else if (m_hold) begin
        if (!lv0) begin
          m_hold  = 0;
          m_armed = bus.req;
        end
      end else if (m_armed) begin
        if (!bus.req) m_armed = 0;
        else if (pr0) begin
          m_armed = 0;
          m_done  = 1;
          m_valid = 1;
          m_data  = extend(bus.switches, bus.sign_ext);
        end
      end else if (bus.req) begin
        m_armed = 1;
      end
      for (int i = 0; i < N_BTN; i++) begin
        sv = 0;
        if (pq[i].size() == 2) sv = pq[i][0];
        pq[i].push_back(~btn_raw[i]);
        if (pq[i].size() > 2) void'(pq[i].pop_front());
        wq[i].push_back(sv);
        if (wq[i].size() > DB) void'(wq[i].pop_front());
        all_diff = (wq[i].size() == DB);
        foreach (wq[i][j]) if (wq[i][j] == m_level[i]) all_diff = 0;
        m_press[i] = m_rose[i];
        m_rose[i]  = 0;
        if (all_diff) begin
          m_level[i] = ~m_level[i];
          m_rose[i]  = m_level[i];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("stall", 64'(bus.stall), 64'(bus.req & ~m_done));
    chk("valid", 64'(bus.valid), 64'(m_valid));
    chk("data_out", 64'(bus.data_out), 64'(m_data));
    chk("btn_level", 64'(btn_level), 64'(m_level));
    chk("btn_press", 64'(btn_press), 64'(m_press));
    if (bus.valid) valid_cnt++;
    if (btn_press[1]) press1_cnt++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      seen = bus.valid;
    end
    if (!seen) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int rise, first_press, npress, v0, p0;
    int hold[N_BTN];
    n_reset = 1'b0; btn_raw = '0; bus.req = 1'b0; bus.sign_ext = 1'b0; bus.switches = '0;

    // Reset with buttons held down, then watch the level rise after release.
    steps(3);
    chk("reset_level", 64'(btn_level), 64'd0);
    chk("reset_valid", 64'(bus.valid), 64'd0);
    n_reset = 1'b1;
    rise = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (btn_level[0] && rise == 0) rise = c;
    end
    chk("reset_rise_cycles", 64'(rise), 64'd6);
    btn_raw = '1;
    steps(10);

    // Bouncing enter button then a clean hold.
    for (int s = 0; s < 10; s++) begin
      btn_raw[0] = (s % 2 == 0) ? 1'b0 : 1'b1;
      steps(2);
    end
    btn_raw[0] = 1'b0;
    first_press = 0; npress = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (btn_press[0]) begin
        npress++;
        if (first_press == 0) first_press = c;
      end
    end
    chk("bounce_press_at", 64'(first_press), 64'd7);
    chk("bounce_press_count", 64'(npress), 64'd1);
    btn_raw[0] = 1'b1;
    steps(10);

    // Input reads, sign- and zero-extended.
    for (int sx = 1; sx >= 0; sx--) begin
      bus.switches = 16'h8001; bus.sign_ext = sx[0]; bus.req = 1'b1;
      step();
      chk("read_stall", 64'(bus.stall), 64'd1);
      btn_raw[0] = 1'b0;
      wait_valid(20);
      chk("read_data", 64'(bus.data_out), (sx == 1) ? 64'hFFFF_8001 : 64'h0000_8001);
      bus.req = 1'b0;
      step();
      chk("read_valid_one_cycle", 64'(bus.valid), 64'd0);
      btn_raw[0] = 1'b1;
      steps(10);
    end

    // One held press must serve only one of two back-to-back requests.
    v0 = valid_cnt;
    bus.req = 1'b1; btn_raw[0] = 1'b0;
    steps(30);
    chk("held_one_valid", 64'(valid_cnt - v0), 64'd1);
    btn_raw[0] = 1'b1;
    steps(10);
    chk("held_still_one", 64'(valid_cnt - v0), 64'd1);
    btn_raw[0] = 1'b0;
    steps(15);
    chk("held_second_valid", 64'(valid_cnt - v0), 64'd2);
    bus.req = 1'b0; btn_raw[0] = 1'b1;
    steps(10);

    // Abort by dropping req, then reset while in DONE.
    v0 = valid_cnt;
    bus.switches = 16'h1234;
    bus.req = 1'b1; steps(3);
    bus.req = 1'b0; btn_raw[0] = 1'b0;
    steps(15);
    chk("abort_no_valid", 64'(valid_cnt - v0), 64'd0);
    chk("abort_data_kept", 64'(bus.data_out), 64'h0000_8001);
    btn_raw[0] = 1'b1; steps(10);
    bus.req = 1'b1; btn_raw[0] = 1'b0;
    wait_valid(20);
    n_reset = 1'b0;
    step();
    chk("reset_in_done_valid", 64'(bus.valid), 64'd0);
    n_reset = 1'b1; bus.req = 1'b0; btn_raw[0] = 1'b1;
    steps(10);

    // Non-enter button during a request.
    v0 = valid_cnt; p0 = press1_cnt;
    bus.req = 1'b1; btn_raw[1] = 1'b0;
    steps(15);
    chk("btn1_press", 64'(press1_cnt - p0), 64'd1);
    chk("btn1_no_valid", 64'(valid_cnt - v0), 64'd0);
    chk("btn1_stall", 64'(bus.stall), 64'd1);
    btn_raw[1] = 1'b1; bus.req = 1'b0;
    steps(10);

    // Random traffic against the model.
    for (int i = 0; i < N_BTN; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 12);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 15) == 0) bus.req = ~bus.req;
      n_reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      bus.switches = 16'($urandom);
      bus.sign_ext = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_input_unit.md
# io_input_unit

Parametrised input front-end for the bbtron CPU: debounces N push-buttons, produces one-cycle press pulses, and runs the input-instruction handshake. The CPU stalls while the unit waits for an enter press; on the press the switch word is latched, extended to the datapath width and presented. It replaces the separate single-button debouncer and enter-flag logic and sits between the board I/O and the control unit / input mux.

## Interface
Parameters:
- DATA_W, 16, switch word width.
- OUT_W, 32, output data width (OUT_W >= DATA_W).
- N_BTN, 2, number of buttons; button 0 is enter.
- DB_CYCLES, 50000, consecutive stable cycles required before the debounced level changes (>= 1).

Ports:
- clock  in  1  single system clock; all state on the rising edge.
- n_reset  in  1  synchronous, active-low reset.
- btn_raw  in  N_BTN  raw buttons, active-low (0 = pressed), asynchronous to clock.
- switches  in  DATA_W  raw switch word, sampled only at capture.
- req  in  1  CPU is executing an input instruction.
- sign_ext  in  1  1 = sign-extend, 0 = zero-extend at capture.
- stall  out  1  hold PC / hold writeback.
- valid  out  1  one-cycle pulse: data_out is the captured word.
- data_out  out  OUT_W  captured, extended switch word; held until the next capture.
- btn_level  out  N_BTN  debounced pressed level, active-high.
- btn_press  out  N_BTN  one-cycle pulse on each debounced press.

## Operation
- Per channel: invert, then a 2-flop synchroniser. A counter increments while the synchronised value differs from btn_level and clears when they agree. When the counter reaches DB_CYCLES-1 while still differing, btn_level toggles and the counter clears. btn_press[i] is asserted on the cycle after btn_level[i] goes 0->1.
- Handshake FSM states: IDLE, WAIT_PRESS, DONE, WAIT_RELEASE.
  - IDLE: if req, go to WAIT_PRESS. Presses without req are discarded, not buffered.
  - WAIT_PRESS: on btn_press[0], load data_out with {extend(switches)} and go to DONE. If req drops, go to IDLE with no capture.
  - DONE: valid=1 for exactly one cycle. Go to WAIT_RELEASE if btn_level[0]=1, else IDLE.
  - WAIT_RELEASE: go to IDLE when btn_level[0]=0. One physical press never satisfies two requests.
- stall = req & (state != DONE). This is combinational, so stall is high in the same cycle req first rises.
- Extension: bits [OUT_W-1:DATA_W] take switches[DATA_W-1] if sign_ext=1, else 0. If OUT_W = DATA_W there is no extension.
- Presses on buttons 1..N_BTN-1 only drive btn_press/btn_level; they have no FSM effect.

## Timing
- Reset values (n_reset=0 at a clock edge): state=IDLE, all counters 0, synchronisers 0, btn_level=0, btn_press=0, valid=0, data_out=0. stall still follows req combinationally, so it is 1 if req=1 during reset.
- Reset asserted mid-handshake returns the FSM to IDLE next edge; no valid pulse is produced.
- Press latency: the raw edge reaches btn_level after 2 sync cycles + DB_CYCLES cycles. btn_press follows 1 cycle later, and valid 1 cycle after btn_press.
- Glitches shorter than DB_CYCLES cycles produce no level change.
- btn_press[0] coinciding with the cycle req rises (FSM in IDLE) is ignored: capture needs WAIT_PRESS.
- req held across DONE: stall=0 in DONE, so the CPU advances exactly one instruction. If req is still 1 in the next cycle (next input instruction), handling is:
  - FSM in IDLE: go to WAIT_PRESS.
  - FSM in WAIT_RELEASE: stay there with stall=1, then go to WAIT_PRESS after release.
  - Required fix to the rule above: WAIT_RELEASE goes to WAIT_PRESS (not IDLE) when req=1 at release.

## Structure
- Package io_input_pkg holds the FSM state enum (2-bit encoding IDLE=0, WAIT_PRESS=1, DONE=2, WAIT_RELEASE=3) and the counter width function clog2(DB_CYCLES).
- One sub-module, debounce_channel (sync + counter + level + press pulse), generated N_BTN times. The FSM and capture register live in io_input_unit.

## Test plan
Use DB_CYCLES=4, DATA_W=16, OUT_W=32 unless noted.
- Reset: drive n_reset=0 with btn_raw all 0 (pressed), then release. Required: all outputs 0 during reset; btn_level[0] rises 6 cycles after release.
- Bounce: toggle btn_raw[0] every 2 cycles for 20 cycles, then hold low. Required: a single btn_press[0] pulse, 7 cycles after the final hold begins.
- Input read: req=1, switches=16'h8001, sign_ext=1, then press. Required: stall=1 until DONE, valid for 1 cycle, data_out=32'hFFFF8001. With sign_ext=0, data_out=32'h00008001.
- Held button across two reads: two back-to-back req with the button held throughout. Required: exactly one valid. A second valid appears only after release and a new press.
- Abort and reset: drop req in WAIT_PRESS, then press. Required: no valid and data_out unchanged. Assert n_reset=0 in DONE. Required: valid=0 on the next cycle.
- Other buttons: press btn_raw[1] with req=1. Required: btn_press[1] pulses; stall stays 1; no valid.
